dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data port. Accepts load/store requests (addr, byte_sel, wdata, we)
//  and serves them from a word-wide single-port synchronous RAM without byte-write enables.
//  Sub-word stores use read-modify-write. Loads return the addressed data right-aligned; the core's
//  bit-select stage extends it. Sits between the core data port and on-chip data RAM.
// PARAMETERS
//  DEPTH_LOG2  10  log2 of RAM depth in 32-bit words; word index = mem_addr[DEPTH_LOG2+1:2]
// PORTS
//  clk           in   1   clock; all state updates on its rising edge
//  rst           in   1   synchronous reset, active-high
//  mem_req       in   1   request valid; core holds req and all request fields stable until mem_ready
//  mem_addr      in   32  byte address; bits above DEPTH_LOG2+1 ignored (memory aliases)
//  mem_byte_sel  in   2   00 byte, 01 half, 10 word, 11 illegal
//  mem_we        in   1   1 = store, 0 = load
//  mem_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  mem_rdata     out  32  load data, right-aligned; valid while mem_ready=1, held until next response
//  mem_ready     out  1   one-cycle completion pulse
//  mem_err       out  1   qualifies mem_ready: access was misaligned or illegal
// BEHAVIOUR
//  - Reset: state IDLE; mem_ready=0, mem_err=0, mem_rdata=0. RAM contents not reset. Outputs registered.
//  - FSM states:
//    - IDLE: on mem_req=1, capture addr/byte_sel/we/wdata into request regs.
//      - illegal/misaligned -> RESP with err=1.
//      - word store -> write RAM this cycle, go RESP.
//      - load or sub-word store -> issue RAM read, go RD (load) or RMW (sub-word store).
//    - RD: RAM data valid; mem_rdata <= word >> (8*addr[1:0]), zero-filled. Go RESP.
//    - RMW: merge captured wdata into the RAM word; write it back this cycle. Go RESP.
//      - Byte: lane addr[1:0].
//      - Half: lane addr[1] (bits [15:0] or [31:16]).
//    - RESP: mem_ready=1 (mem_err as captured) for exactly one cycle. mem_req is ignored here, so a
//      held request is never serviced twice. Go IDLE.
//  - Latency from the IDLE cycle that samples req (cycle n) to mem_ready high:
//    - word store, error: n+1
//    - load, sub-word store: n+2
//    - Back-to-back requests: next one is sampled at the earliest in the cycle after RESP.
//  - Misaligned access = half with addr[0]=1, word with addr[1:0]!=0, or byte_sel=11.
//    - No RAM access; mem_rdata unchanged; err=1 with ready.
//  - mem_err=0 on every non-error response. mem_ready is 0 in all states but RESP.
//  - Request fields are sampled only in IDLE; changes while busy are ignored.
//  - rst=1 in any state wins: no RAM write that cycle (RMW aborted, word left unmodified); next state IDLE.
//  - Load data after a store to the same word reflects the store (write completes before RESP).
// STRUCTURE
//  - Shared header mem_defs.vh (team package): MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10, MEM_ILL=2'b11.
//    Same encoding the core drives from funct3[1:0].
//  - FSM state localparams stay local: IDLE, RD, RMW, RESP.
//  - One sub-module: sp_ram (DEPTH_LOG2 param; clk, en, we, addr, wdata, rdata; 1-cycle read, read-first).
//  - Responder holds the FSM, request regs, lane merge and read alignment.
// TESTING
//  1 Word store 0xDEADBEEF @0x10, then word load @0x10 -> ready at n+1, then rdata=0xDEADBEEF at n+2, err=0.
//  2 After test 1, byte store 0xAA @0x12 -> word becomes 0xDEAABEEF.
//    Then half load @0x12 -> rdata=0x0000DEAA; byte load @0x13 -> 0x000000DE.
//  3 Half store @0x11 or word load @0x16 or byte_sel=11 -> ready at n+1 with err=1.
//    Memory and mem_rdata unchanged.
//  4 req held high for 5 cycles on one word store -> exactly one ready pulse, one RAM write.
//    Next req serviced only from the cycle after RESP.
//  5 rst asserted during RMW of byte store 0x55 @0x20 (word 0x11223344) -> word stays 0x11223344.
//    Outputs at reset values next cycle.
//  6 Aliasing: word store @0x0000_1000 with DEPTH_LOG2=10 -> readable at @0x0.
//    Random scoreboard of 2000 mixed accesses against a byte-array model; no mismatches.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: access size encoding,
// alignment check and sub-word lane merge.
package dmem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned HALF_W = 16;

  // Same encoding the core drives from funct3[1:0]
  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_ILL = 2'b11
  } mem_size_e;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      MEM_B:   is_misaligned = 1'b0;
      MEM_H:   is_misaligned = lo[0];
      MEM_W:   is_misaligned = |lo;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Halves pick the lane with lo[1]; anything else is treated as a byte store
  function automatic logic [DATA_W-1:0] merge_lane(input mem_size_e         size,
                                                   input logic [1:0]        lo,
                                                   input logic [DATA_W-1:0] word,
                                                   input logic [HALF_W-1:0] wd);
    logic [DATA_W-1:0] m;
    m = word;
    if (size == MEM_H) begin
      if (lo[1]) m[31:16] = wd;
      else       m[15:0]  = wd;
    end else begin
      case (lo)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_sp_ram.sv
// Word-wide single-port synchronous RAM: one-cycle read latency, read-first on write.
module dmem_responder_sp_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem_q[addr];
      if (we) mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port: word stores go straight to RAM,
// sub-word stores use read-modify-write, loads return right-aligned data.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_byte_sel,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, RD, RMW, RESP} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  mem_size_e         size_q, size_d;
  logic [HALF_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic                  ram_en_c, ram_we_c;
  logic [DEPTH_LOG2-1:0] ram_addr_c;
  logic [DATA_W-1:0]     ram_wdata_c, ram_rdata;
  mem_size_e             req_size_c;
  logic                  unused_addr_hi;

  assign req_size_c     = mem_size_e'(mem_byte_sel);
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:AW];

  dmem_responder_sp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en_c),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .wdata(ram_wdata_c),
    .rdata(ram_rdata)
  );

  // Next-state, RAM control and registered-output next values
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = addr_q[AW-1:2];
    ram_wdata_c = merge_lane(size_q, addr_q[1:0], ram_rdata, wdata_q);

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d     = mem_addr[AW-1:0];
          size_d     = req_size_c;
          wdata_d    = mem_wdata[HALF_W-1:0];
          ram_addr_c = mem_addr[AW-1:2];
          if (is_misaligned(req_size_c, mem_addr[1:0])) begin
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = RESP;
          end else if (mem_we && (req_size_c == MEM_W)) begin
            ram_en_c    = 1'b1;
            ram_we_c    = 1'b1;
            ram_wdata_c = mem_wdata;
            ready_d     = 1'b1;
            state_d     = RESP;
          end else begin
            ram_en_c = 1'b1;
            state_d  = mem_we ? RMW : RD;
          end
        end
      end
      RD: begin
        rdata_d = ram_rdata >> {addr_q[1:0], 3'b000};
        ready_d = 1'b1;
        state_d = RESP;
      end
      RMW: begin
        ram_en_c = 1'b1;
        ram_we_c = 1'b1;
        ready_d  = 1'b1;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reset aborts any pending write so the RAM word stays untouched
    if (rst) begin
      ram_en_c = 1'b0;
      ram_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= MEM_B;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and scoreboarded checks for dmem_responder: latency, lane merge,
// alignment errors, held requests, reset during RMW and address aliasing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [1:0]  mem_byte_sel;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_byte_sel(mem_byte_sel),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_err     (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transfer from IDLE; returns cycles to ready plus the response, then waits out RESP
  task automatic xfer(input logic [31:0] a, input logic [1:0] sel, input logic w,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic er);
    mem_req = 1'b1; mem_addr = a; mem_byte_sel = sel; mem_we = w; mem_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 10);
    if (!mem_ready) check("ready_timeout", 32'(mem_ready), 32'd1);
    rd = mem_rdata;
    er = mem_err;
    mem_req = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse_end", 32'(mem_ready), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic [7:0]  mb [64];
  logic [31:0] last_rd;

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_byte_sel = '0; mem_we = 1'b0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // word store then load
    xfer(32'h10, 2'b10, 1'b1, 32'hDEADBEEF, lat, rd, er);
    check("t1_st_lat", 32'(lat), 32'd1);
    check("t1_st_err", 32'(er), 32'd0);
    xfer(32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er);
    check("t1_ld_lat", 32'(lat), 32'd2);
    check("t1_ld_data", rd, 32'hDEADBEEF);
    check("t1_ld_err", 32'(er), 32'd0);

    // byte RMW and sub-word loads
    xfer(32'h12, 2'b00, 1'b1, 32'hFFFF_FFAA, lat, rd, er);
    check("t2_sb_lat", 32'(lat), 32'd2);
    check("t2_sb_err", 32'(er), 32'd0);
    xfer(32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er);
    check("t2_word", rd, 32'hDEAABEEF);
    xfer(32'h12, 2'b01, 1'b0, 32'h0, lat, rd, er);
    check("t2_half", rd, 32'h0000DEAA);
    xfer(32'h13, 2'b00, 1'b0, 32'h0, lat, rd, er);
    check("t2_byte", rd, 32'h000000DE);
    check("t2_byte_lat", 32'(lat), 32'd2);

    // misaligned / illegal: err, no RAM access, rdata held
    xfer(32'h11, 2'b01, 1'b1, 32'h0000FFFF, lat, rd, er);
    check("t3_sh_lat", 32'(lat), 32'd1);
    check("t3_sh_err", 32'(er), 32'd1);
    check("t3_sh_rd", rd, 32'h000000DE);
    xfer(32'h16, 2'b10, 1'b0, 32'h0, lat, rd, er);
    check("t3_lw_lat", 32'(lat), 32'd1);
    check("t3_lw_err", 32'(er), 32'd1);
    check("t3_lw_rd", rd, 32'h000000DE);
    xfer(32'h10, 2'b11, 1'b1, 32'h12345678, lat, rd, er);
    check("t3_ill_err", 32'(er), 32'd1);
    check("t3_ill_rd", rd, 32'h000000DE);
    xfer(32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er);
    check("t3_mem_kept", rd, 32'hDEAABEEF);
    check("t3_ok_err", 32'(er), 32'd0);

    // request held through RESP, next one taken in the cycle after RESP
    mem_req = 1'b1; mem_addr = 32'h30; mem_byte_sel = 2'b10; mem_we = 1'b1; mem_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("t4_resp", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    check("t4_no_second", 32'(mem_ready), 32'd0);
    mem_we = 1'b0;
    @(posedge clk); #1;
    check("t4_rd_state", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    check("t4_next_ready", 32'(mem_ready), 32'd1);
    check("t4_next_data", mem_rdata, 32'hCAFEF00D);
    mem_req = 1'b0;
    @(posedge clk); #1;
    check("t4_idle", 32'(mem_ready), 32'd0);

    // reset during RMW leaves the word untouched
    xfer(32'h20, 2'b10, 1'b1, 32'h11223344, lat, rd, er);
    mem_req = 1'b1; mem_addr = 32'h20; mem_byte_sel = 2'b00; mem_we = 1'b1; mem_wdata = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_ready", 32'(mem_ready), 32'd0);
    check("t5_rst_err", 32'(mem_err), 32'd0);
    check("t5_rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(32'h20, 2'b10, 1'b0, 32'h0, lat, rd, er);
    check("t5_word_kept", rd, 32'h11223344);

    // aliasing above the RAM depth
    xfer(32'h1000, 2'b10, 1'b1, 32'h13572468, lat, rd, er);
    xfer(32'h0, 2'b10, 1'b0, 32'h0, lat, rd, er);
    check("t6_alias", rd, 32'h13572468);
    last_rd = rd;

    // random scoreboard over 16 words at 0x100, with aliased upper bits
    for (int i = 0; i < 64; i += 4) begin
      logic [31:0] v;
      v = $urandom;
      xfer(32'h100 + 32'(i), 2'b10, 1'b1, v, lat, rd, er);
      {mb[i+3], mb[i+2], mb[i+1], mb[i]} = v;
    end
    for (int n = 0; n < 2000; n++) begin
      int          off;
      logic [1:0]  sel;
      logic        w, mis;
      logic [31:0] wd, a, word, exp_rd;
      int          exp_lat;
      off = int'($urandom_range(0, 63));
      a   = 32'h100 + 32'(off) + (32'($urandom_range(0, 3)) << 12);
      sel = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      wd  = $urandom;
      mis = (sel == 2'b11) || (sel == 2'b01 && off[0]) || (sel == 2'b10 && off[1:0] != 2'b00);
      xfer(a, sel, w, wd, lat, rd, er);
      exp_rd = last_rd;
      if (mis) begin
        exp_lat = 1;
      end else if (w) begin
        exp_lat = (sel == 2'b10) ? 1 : 2;
        mb[off] = wd[7:0];
        if (sel != 2'b00) mb[off+1] = wd[15:8];
        if (sel == 2'b10) begin mb[off+2] = wd[23:16]; mb[off+3] = wd[31:24]; end
      end else begin
        int wb;
        exp_lat = 2;
        wb = off & ~3;
        word = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
        exp_rd = word >> (8 * (off & 3));
        last_rd = exp_rd;
      end
      check("rnd_lat", 32'(lat), 32'(exp_lat));
      check("rnd_err", 32'(er), 32'(mis));
      check("rnd_rdata", rd, exp_rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
